// File: rtl/instruction_fetch_unit_if.sv
// Instruction stream handshake between the fetch unit (master) and the decode stage (slave).
interface instruction_fetch_unit_if #(
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned ADDR_W  = 4
);
   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instr_data;
   logic [ADDR_W-1:0]  instr_addr;

   modport master (
      output instr_valid,
      output instr_data,
      output instr_addr,
      input  instr_ready
   );

   modport slave (
      input  instr_valid,
      input  instr_data,
      input  instr_addr,
      output instr_ready
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction store plus sequencer: loads a program, then streams it out under valid/ready until a halt opcode.
// Optional feature: define IFU_JUMP_EN to honour jump_valid/jump_addr redirects during a run.
module instruction_fetch_unit #(
   parameter int unsigned     INSTR_W     = 16,
   parameter int unsigned     DEPTH       = 16,
   parameter int unsigned     ADDR_W      = $clog2(DEPTH),
   parameter int unsigned     OPC_W       = 4,
   parameter logic [OPC_W-1:0] HALT_OPCODE = 4'hF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load_en,
   input  logic [ADDR_W-1:0]      load_addr,
   input  logic [INSTR_W-1:0]     load_data,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      start_addr,
   input  logic                   stop,
   input  logic                   jump_valid,
   input  logic [ADDR_W-1:0]      jump_addr,
   instruction_fetch_unit_if.master instr,
   output logic                   busy,
   output logic                   halted
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   logic [INSTR_W-1:0] mem [DEPTH];

   state_t             state, state_d;
   logic [ADDR_W-1:0]  pc, pc_d;
   logic               valid_q, valid_d;
   logic [INSTR_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               busy_d, halted_d;
   logic               mem_we;
   logic               out_free;
   logic [INSTR_W-1:0] rd_word;

   assign out_free = !valid_q || instr.instr_ready;
   assign rd_word  = mem[pc];

   assign instr.instr_valid = valid_q;
   assign instr.instr_data  = data_q;
   assign instr.instr_addr  = addr_q;

`ifndef IFU_JUMP_EN
   logic unused_jump;
   assign unused_jump = ^{jump_valid, jump_addr};
`endif

   // Program store: survives reset, writable only while no run is active.
   always_ff @(posedge clk) begin
      if (mem_we) mem[load_addr] <= load_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         pc      <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         addr_q  <= '0;
         busy    <= 1'b0;
         halted  <= 1'b0;
      end else begin
         state   <= state_d;
         pc      <= pc_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         busy    <= busy_d;
         halted  <= halted_d;
      end
   end

   always_comb begin
      state_d = state;
      pc_d    = pc;
      valid_d = valid_q;
      data_d  = data_q;
      addr_d  = addr_q;
      mem_we  = 1'b0;

      case (state)
         S_IDLE, S_HALT: begin
            mem_we = load_en;
            if (start) begin
               pc_d    = start_addr;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (out_free) begin
               data_d  = rd_word;
               addr_d  = pc;
               valid_d = 1'b1;
               // A halt word is presented but the pc parks on it until it drains.
               if (rd_word[INSTR_W-1 -: OPC_W] == HALT_OPCODE) state_d = S_DRAIN;
               else                                           pc_d    = pc + ADDR_W'(1);
            end
         end
         S_DRAIN: begin
            if (valid_q && instr.instr_ready) begin
               valid_d = 1'b0;
               state_d = S_HALT;
            end
         end
         default: state_d = S_IDLE;
      endcase

`ifdef IFU_JUMP_EN
      // Redirect flushes the output register, accepted or not.
      if (jump_valid && (state == S_FETCH || state == S_DRAIN)) begin
         pc_d    = jump_addr;
         valid_d = 1'b0;
         state_d = S_FETCH;
      end
`endif

      if (stop) begin
         state_d = S_IDLE;
         valid_d = 1'b0;
      end

      busy_d   = (state_d == S_FETCH) || (state_d == S_DRAIN);
      halted_d = (state_d == S_HALT);
   end

endmodule
